// File: rtl/cam_pkg.sv
// Shared Bayer definitions for the raw-to-RGB demosaic path: pattern encodings,
// the per-cell colour lookup and RGB888 field placement.
package cam_pkg;

  typedef enum logic [1:0] {COL_R, COL_G, COL_B} colour_t;

  localparam int BAYER_RGGB = 0;
  localparam int BAYER_GRBG = 1;
  localparam int BAYER_GBRG = 2;
  localparam int BAYER_BGGR = 3;

  localparam int RGB_PIX_W = 24;
  localparam int RGB_R_LSB = 16;
  localparam int RGB_G_LSB = 8;
  localparam int RGB_B_LSB = 0;

  // Colour of the pixel at row parity y0, column parity x0 for a given pattern.
  function automatic colour_t colour(input int pattern, input logic y0, input logic x0);
    colour_t c;
    c = COL_G;
    case (pattern)
      BAYER_RGGB: begin
        if ({y0, x0} == 2'b00) c = COL_R;
        else if ({y0, x0} == 2'b11) c = COL_B;
      end
      BAYER_GRBG: begin
        if ({y0, x0} == 2'b01) c = COL_R;
        else if ({y0, x0} == 2'b10) c = COL_B;
      end
      BAYER_GBRG: begin
        if ({y0, x0} == 2'b10) c = COL_R;
        else if ({y0, x0} == 2'b01) c = COL_B;
      end
      default: begin
        if ({y0, x0} == 2'b11) c = COL_R;
        else if ({y0, x0} == 2'b00) c = COL_B;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_bayer_2x2.sv
// Routes the four samples of a 2x2 Bayer window onto R, the two G terms and B,
// based on the colour of the window's own (bottom-right) position.
module cam_bayer_2x2
  import cam_pkg::*;
#(
  parameter int P_DEPTH       = 10,
  parameter int BAYER_PATTERN = 0
) (
  input  logic               y0,
  input  logic               x0,
  input  logic [P_DEPTH-1:0] cur,
  input  logic [P_DEPTH-1:0] left,
  input  logic [P_DEPTH-1:0] up,
  input  logic [P_DEPTH-1:0] up_left,
  output logic [P_DEPTH-1:0] r,
  output logic [P_DEPTH-1:0] g_a,
  output logic [P_DEPTH-1:0] g_b,
  output logic [P_DEPTH-1:0] b
);

  // G samples always sit on a diagonal, so the window splits into two cases.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    r   = cur;
    g_a = left;
    g_b = up;
    b   = up_left;
    if (colour(BAYER_PATTERN, y0, x0) == COL_G) begin
      g_a = cur;
      g_b = up_left;
      if (colour(BAYER_PATTERN, y0, ~x0) == COL_R) begin
        r = left;
        b = up;
      end else begin
        r = up;
        b = left;
      end
    end else if (colour(BAYER_PATTERN, y0, x0) == COL_B) begin
      r = up_left;
      b = cur;
    end
  end

endmodule

// File: rtl/cam_raw_to_rgb.sv
// 2PPC bilinear 2x2 demosaic: tracks frame position, builds each pixel's window
// from the current/previous row beats plus the held left column, 2-cycle latency.
module cam_raw_to_rgb
  import cam_pkg::*;
#(
  parameter int P_DEPTH       = 10,
  parameter int PW            = P_DEPTH * 2,
  parameter int FRAME_WIDTH   = 640,
  parameter int BAYER_PATTERN = 0
) (
  input  logic          i_pclk,
  input  logic          i_arstn,
  input  logic          i_vsync,
  input  logic          i_valid,
  input  logic [PW-1:0] i_p_01,
  input  logic [PW-1:0] i_p_11,
  output logic          o_vsync,
  output logic          o_valid,
  output logic [47:0]   o_rgb
);

  localparam int PAIRS = FRAME_WIDTH / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST_PAIR = CW'(PAIRS - 1);

  logic               vsync_q;
  logic [CW-1:0]      pair_cnt;
  logic               row_par;
  logic               first_row;
  logic [P_DEPTH-1:0] held_cur;
  logic [P_DEPTH-1:0] held_up;

  logic               vsync_fall;
  logic [CW-1:0]      cnt_eff;
  logic               row_par_eff;
  logic               first_eff;
  logic               col0;
  logic               last_pair;

  logic [1:0][P_DEPTH-1:0] cur;
  logic [1:0][P_DEPTH-1:0] up;
  logic [P_DEPTH-1:0]      left0;
  logic [P_DEPTH-1:0]      up_left0;
  logic [1:0][P_DEPTH-1:0] sel_r, sel_ga, sel_gb, sel_b;

  logic                    s1_vsync, s1_valid;
  logic [1:0][P_DEPTH-1:0] s1_r, s1_ga, s1_gb, s1_b;
  logic [1:0][P_DEPTH:0]   g_sum;

  // A vsync fall in the same cycle as a beat makes that beat pair 0 of row 0.
  assign vsync_fall  = vsync_q & ~i_vsync;
  assign cnt_eff     = vsync_fall ? '0 : pair_cnt;
  assign row_par_eff = row_par & ~vsync_fall;
  assign first_eff   = first_row | vsync_fall;
  assign col0        = (cnt_eff == '0);
  assign last_pair   = (cnt_eff == LAST_PAIR);

  assign cur      = i_p_01;
  assign up       = first_eff ? '0 : i_p_11;
  assign left0    = col0 ? cur[1] : held_cur;
  assign up_left0 = col0 ? up[1] : (first_eff ? '0 : held_up);

  cam_bayer_2x2 #(.P_DEPTH(P_DEPTH), .BAYER_PATTERN(BAYER_PATTERN)) u_pix0 (
    .y0(row_par_eff), .x0(1'b0), .cur(cur[0]), .left(left0), .up(up[0]), .up_left(up_left0),
    .r(sel_r[0]), .g_a(sel_ga[0]), .g_b(sel_gb[0]), .b(sel_b[0])
  );

  cam_bayer_2x2 #(.P_DEPTH(P_DEPTH), .BAYER_PATTERN(BAYER_PATTERN)) u_pix1 (
    .y0(row_par_eff), .x0(1'b1), .cur(cur[1]), .left(cur[0]), .up(up[1]), .up_left(up[0]),
    .r(sel_r[1]), .g_a(sel_ga[1]), .g_b(sel_gb[1]), .b(sel_b[1])
  );

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      vsync_q   <= 1'b0;
      pair_cnt  <= '0;
      row_par   <= 1'b0;
      first_row <= 1'b1;
      held_cur  <= '0;
      held_up   <= '0;
    end else begin
      vsync_q <= i_vsync;
      if (i_valid) begin
        pair_cnt  <= last_pair ? '0 : cnt_eff + CW'(1);
        row_par   <= row_par_eff ^ last_pair;
        first_row <= first_eff & ~last_pair;
        held_cur  <= cur[1];
        held_up   <= i_p_11[PW-1:P_DEPTH];
      end else if (vsync_fall) begin
        pair_cnt  <= '0;
        row_par   <= 1'b0;
        first_row <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      s1_vsync <= 1'b0;
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_ga    <= '0;
      s1_gb    <= '0;
      s1_b     <= '0;
    end else begin
      s1_vsync <= i_vsync;
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_r  <= sel_r;
        s1_ga <= sel_ga;
        s1_gb <= sel_gb;
        s1_b  <= sel_b;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      g_sum[i] = {1'b0, s1_ga[i]} + {1'b0, s1_gb[i]};
    end
  end

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      o_vsync <= 1'b0;
      o_valid <= 1'b0;
      o_rgb   <= '0;
    end else begin
      o_vsync <= s1_vsync;
      o_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < 2; i++) begin
          o_rgb[i*RGB_PIX_W + RGB_R_LSB +: 8] <= s1_r[i][P_DEPTH-1:P_DEPTH-8];
          o_rgb[i*RGB_PIX_W + RGB_G_LSB +: 8] <= g_sum[i][P_DEPTH:P_DEPTH-7];
          o_rgb[i*RGB_PIX_W + RGB_B_LSB +: 8] <= s1_b[i][P_DEPTH-1:P_DEPTH-8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_raw_to_rgb.sv
// Bench for cam_raw_to_rgb: four instances (one per Bayer pattern) fed from image
// arrays, each output pixel compared with a window-averaging reference model.
module tb_cam_raw_to_rgb;

  localparam int P     = 10;
  localparam int PW    = 2 * P;
  localparam int FW    = 8;
  localparam int PAIRS = FW / 2;
  localparam int ROWS  = 4;
  localparam int NPAT  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync;
  logic          valid;
  logic [PW-1:0] p01 [NPAT];
  logic [PW-1:0] p11 [NPAT];
  logic          o_vsync [NPAT];
  logic          o_valid [NPAT];
  logic [47:0]   o_rgb   [NPAT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NPAT; g++) begin : g_dut
    cam_raw_to_rgb #(.P_DEPTH(P), .PW(PW), .FRAME_WIDTH(FW), .BAYER_PATTERN(g)) u_dut (
      .i_pclk (clk),
      .i_arstn(rst_n),
      .i_vsync(vsync),
      .i_valid(valid),
      .i_p_01 (p01[g]),
      .i_p_11 (p11[g]),
      .o_vsync(o_vsync[g]),
      .o_valid(o_valid[g]),
      .o_rgb  (o_rgb[g])
    );
  end

  typedef struct packed {
    logic                   vs;
    logic                   vl;
    logic                   cap_en;
    logic [1:0]             y;
    logic [1:0]             k;
    logic [NPAT-1:0][47:0]  rgb;
  } exp_t;

  int          img [NPAT][ROWS][FW];
  logic [23:0] cap [NPAT][ROWS][FW];
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic byte chan(input int p, input int yy, input int xx);
    string s;
    case (p)
      0:       s = "RGGB";
      1:       s = "GRBG";
      2:       s = "GBRG";
      default: s = "BGGR";
    endcase
    return s[((yy & 1) * 2) + (xx & 1)];
  endfunction

  // Bilinear 2x2: sum samples per colour over columns x-1..x (x-1 mirrored at x=0),
  // rows y-1..y (row -1 reads as zero), then truncate to 8 bits.
  function automatic logic [23:0] ref_pix(input int p, input int x, input int y);
    int rs, gs, bs, xl, yy, xx, v;
    byte c;
    rs = 0; gs = 0; bs = 0;
    xl = (x == 0) ? 1 : x - 1;
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        yy = y - dy;
        xx = (dx == 1) ? xl : x;
        v  = (yy < 0) ? 0 : img[p][yy][xx];
        c  = chan(p, yy, xx);
        if (c == "R") rs += v;
        else if (c == "G") gs += v;
        else bs += v;
      end
    end
    return {8'(rs >> (P - 8)), 8'(gs >> (P - 7)), 8'(bs >> (P - 8))};
  endfunction

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_out(input exp_t e);
    for (int p = 0; p < NPAT; p++) begin
      check($sformatf("o_valid pat%0d", p), 48'(o_valid[p]), 48'(e.vl));
      check($sformatf("o_vsync pat%0d", p), 48'(o_vsync[p]), 48'(e.vs));
      if (e.vl) begin
        check($sformatf("o_rgb pat%0d y%0d k%0d", p, e.y, e.k), o_rgb[p], e.rgb[p]);
        if (e.cap_en) begin
          cap[p][e.y][2*e.k]   = o_rgb[p][23:0];
          cap[p][e.y][2*e.k+1] = o_rgb[p][47:24];
        end
      end
    end
  endtask

  task automatic step(input logic vs, input logic vl, input int y, input int k, input logic ce);
    exp_t e;
    @(negedge clk);
    vsync = vs;
    valid = vl;
    e = '0;
    e.vs = vs; e.vl = vl; e.cap_en = ce; e.y = 2'(y); e.k = 2'(k);
    for (int p = 0; p < NPAT; p++) begin
      if (vl) begin
        p01[p] = {10'(img[p][y][2*k+1]), 10'(img[p][y][2*k])};
        p11[p] = (y > 0) ? {10'(img[p][y-1][2*k+1]), 10'(img[p][y-1][2*k])} : 20'($urandom);
        e.rgb[p] = {ref_pix(p, 2*k+1, y), ref_pix(p, 2*k, y)};
      end else begin
        p01[p] = 20'($urandom);
        p11[p] = 20'($urandom);
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 2) check_out(q.pop_front());
  endtask

  task automatic send_frame(input int nrows, input int last_pairs, input bit bubbles,
                            input logic ce, input int tail);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    for (int y = 0; y < nrows; y++) begin
      for (int k = 0; k < ((y == nrows - 1) ? last_pairs : PAIRS); k++) begin
        if (bubbles && (y != 0 || k != 0))
          repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b1, y, k, ce);
      end
    end
    repeat (tail) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic fill_flat();
    byte c;
    for (int p = 0; p < NPAT; p++)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < FW; x++) begin
          c = chan(p, y, x);
          img[p][y][x] = (c == "R") ? 'h3FC : (c == "G") ? 'h200 : 'h100;
          cap[p][y][x] = 'x;
        end
  endtask

  task automatic fill_random();
    for (int p = 0; p < NPAT; p++)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < FW; x++)
          img[p][y][x] = int'($urandom_range(0, (1 << P) - 1));
  endtask

  task automatic check_flat(input string tag);
    for (int p = 0; p < NPAT; p++)
      for (int y = 1; y < ROWS; y++)
        for (int x = 0; x < FW; x++)
          check($sformatf("%s pat%0d (%0d,%0d)", tag, p, x, y), 48'(cap[p][y][x]), 48'h00FF8040);
  endtask

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    valid = 1'b0;
    for (int p = 0; p < NPAT; p++) begin
      p01[p] = '0;
      p11[p] = '0;
    end
    #12;
    for (int p = 0; p < NPAT; p++) begin
      check($sformatf("reset o_valid pat%0d", p), 48'(o_valid[p]), 48'd0);
      check($sformatf("reset o_vsync pat%0d", p), 48'(o_vsync[p]), 48'd0);
      check($sformatf("reset o_rgb pat%0d", p), o_rgb[p], 48'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 0, 0, 1'b0);

    // Flat field on all four patterns.
    fill_flat();
    send_frame(ROWS, PAIRS, 1'b0, 1'b1, 2);
    check_flat("flat");
    for (int p = 0; p < NPAT; p++)
      for (int x = 0; x < FW; x++)
        if (p < 2) check($sformatf("row0 blue pat%0d x%0d", p, x), 48'(cap[p][0][x][7:0]), 48'd0);
        else       check($sformatf("row0 red pat%0d x%0d", p, x), 48'(cap[p][0][x][23:16]), 48'd0);

    // Column-0 mirror and G averaging on RGGB.
    fill_flat();
    img[0][0][0] = 'h300;
    img[0][1][1] = 'h0C0;
    img[0][0][1] = 'h3FF;
    img[0][1][0] = 'h001;
    send_frame(ROWS, PAIRS, 1'b0, 1'b1, 2);
    check("mirror B (0,1)", 48'(cap[0][1][0][7:0]), 48'h30);
    check("mirror R (0,1)", 48'(cap[0][1][0][23:16]), 48'hC0);
    check("g average (1,1)", 48'(cap[0][1][1][15:8]), 48'h80);

    // Random images with valid bubbles.
    repeat (3) begin
      fill_random();
      send_frame(ROWS, PAIRS, 1'b1, 1'b0, 2);
    end

    // vsync falling mid-line: partial frame, then a fresh frame.
    fill_random();
    send_frame(2, 2, 1'b1, 1'b0, 0);
    fill_random();
    send_frame(ROWS, PAIRS, 1'b1, 1'b0, 2);

    // Async reset mid-line, between clock edges.
    fill_flat();
    send_frame(2, 3, 1'b0, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    vsync = 1'b0;
    valid = 1'b0;
    #1;
    for (int p = 0; p < NPAT; p++) begin
      check($sformatf("async rst o_valid pat%0d", p), 48'(o_valid[p]), 48'd0);
      check($sformatf("async rst o_vsync pat%0d", p), 48'(o_vsync[p]), 48'd0);
      check($sformatf("async rst o_rgb pat%0d", p), o_rgb[p], 48'd0);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 0, 0, 1'b0);
    fill_flat();
    send_frame(ROWS, PAIRS, 1'b0, 1'b1, 2);
    check_flat("post-reset flat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
